param_loader: RTL and testbench
===============================

# param_loader

Streaming loader that fills the parameters memory from an external word stream before inference. Software or the host bridge issues one start command with base address, word count and fixed-point format. The block then accepts a valid/ready stream of parameter words and drives one registered write per accepted word onto the parameters-memory write interface: en, chip_en, addr, data, format. It sits directly upstream of params_mem and is its only writer during load.

## Interface
Parameters:
- DATA_W, 22, width of one parameter word (matches CompFx_t)
- ADDR_W, 15, parameter address width (matches ParamAddr_t)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle load command
- base_addr  in  ADDR_W  first write address, latched on accepted start
- word_count  in  ADDR_W+1  number of words, latched on accepted start
- format_in  in  FxFormatParams_t  format applied to every write, latched on accepted start
- in_valid  in  1  stream word valid
- in_data  in  DATA_W  stream word
- in_ready  out  1  loader accepts a word this cycle
- mem_write_en  out  1  params memory write enable
- mem_chip_en  out  1  params memory chip enable
- mem_write_addr  out  ADDR_W  write address
- mem_write_data  out  DATA_W  write data
- mem_write_format  out  FxFormatParams_t  write format
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- start_err  out  1  one-cycle pulse when start is ignored while busy

## Operation
- FSM states: IDLE, LOAD, LAST.
- IDLE:
  - start with word_count≠0: latch base_addr, word_count and format_in; clear the accepted-word counter; go to LOAD.
  - start with word_count=0: no writes; done pulses the next cycle; stay IDLE.
- LOAD:
  - in_ready=1.
  - Handshake: in_valid && in_ready.
  - Each handshake registers one write: data=in_data, addr=current address, format=latched format. Then the address increments and the counter increments.
  - On the handshake that reaches word_count: go to LAST.
  - in_valid low: no write, no state change; waiting is unbounded.
- LAST: in_ready=0; the final write is visible; done=1 for this cycle; next state IDLE.
- Address arithmetic: the address is ADDR_W bits and wraps modulo 2^ADDR_W (base 0x7FFF, 2 words writes 0x7FFF then 0x0000). No error is raised on wrap.
- start while in LOAD or LAST: ignored, latched values unchanged, start_err pulses the next cycle.
- start in the same cycle as a LOAD handshake: the handshake proceeds normally and start_err pulses.
- mem_chip_en=1 in every cycle of LOAD and LAST; 0 in IDLE.
- busy=1 in LOAD and LAST.
- Reset, including mid-load: state IDLE; all outputs 0; counter and address cleared. A partial load is abandoned and is not resumed; memory contents already written are left as is.

## Timing
- Reset values: in_ready, mem_write_en, mem_chip_en, busy, done and start_err are 0; mem_write_addr and mem_write_data are 0; mem_write_format is 0 (enum value 0).
- start accepted at cycle T: busy=1, mem_chip_en=1 and in_ready=1 from T+1.
- Handshake at cycle N: mem_write_en=1 at N+1, with addr, data and format registered. Write latency is 1 cycle.
- mem_write_en is 0 in any cycle not directly following a handshake.
- Full-rate streaming: one write per cycle, with no bubbles inserted by the loader.
- Last handshake at N: state LAST, final write and done all occur at N+1. busy=0 and in_ready=0 at N+2. A new start is accepted at N+2.
- Zero-count start at T: done=1 at T+1; busy stays 0.

## Configuration
- PARAM_LOADER_CHECKSUM_EN defined:
  - Adds input expected_sum (DATA_W), latched on accepted start.
  - Adds output checksum (DATA_W): sum of accepted words modulo 2^DATA_W, cleared on accepted start, valid when done=1.
  - Adds output checksum_err (1): pulses with done when checksum≠expected_sum.
  - For a zero-count start, checksum=0 and it is compared against expected_sum.
- PARAM_LOADER_CHECKSUM_EN undefined: these ports and the accumulator do not exist. All other behaviour is identical.

## Test plan
- Reset mid-load:
  - Stimulus: assert rst_n=0 after 2 of 4 words.
  - Required: all outputs 0 immediately.
  - Then start base 0x20, count 1: a single write at 0x20, then done.
- Back-to-back load:
  - Stimulus: start base 0x0100, count 4, format F; in_valid held high with words 1,2,3,4.
  - Required: writes at 0x0100..0x0103 on 4 consecutive cycles, each one cycle after its handshake, format F; done coincides with the write to 0x0103.
- Throttled stream:
  - Stimulus: count 3, in_valid toggling 1,0,0,1,0,1.
  - Required: exactly 3 writes, no write in gap cycles, mem_chip_en held 1 throughout.
- Wrap and zero count:
  - Stimulus: base 0x7FFE, count 3.
  - Required: addresses 0x7FFE, 0x7FFF, 0x0000.
  - Then a count-0 start: done one cycle later, no mem_write_en.
- Start while busy:
  - Stimulus: second start (base 0x50) two cycles into a 4-word load.
  - Required: start_err pulse; all 4 writes keep the original base.
- Checksum (macro defined):
  - Stimulus: words 10,20,30 with expected_sum 60.
  - Required: checksum=60, checksum_err=0.
  - Repeat with expected_sum 61: checksum_err=1 with done.

Source files
------------

// File: rtl/param_loader.sv
// param_loader: streaming loader that fills the parameters memory.
//
// A single-cycle start command latches base address, word count and
// fixed-point format. The loader then accepts a valid/ready stream of
// parameter words and issues one registered write per accepted word
// (1-cycle write latency, full-rate, address wraps modulo 2^ADDR_W).
//
// Optional feature macro: PARAM_LOADER_CHECKSUM_EN
//   Adds expected_sum input, checksum output (sum of accepted words
//   modulo 2^DATA_W) and checksum_err pulse aligned with done.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               single-cycle load command
//   base_addr           first write address (latched on accepted start)
//   word_count          number of words (latched on accepted start)
//   format_in           format applied to every write (latched)
//   in_valid/in_data    stream word input
//   in_ready            loader accepts a word this cycle
//   mem_write_en        params memory write enable
//   mem_chip_en         params memory chip enable (whole load)
//   mem_write_addr/data/format  registered write payload
//   busy                load in progress
//   done                one-cycle completion pulse
//   start_err           one-cycle pulse when start is ignored while busy
module param_loader #(
    parameter int DATA_W = 22,
    parameter int ADDR_W = 15,
    parameter int FMT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [FMT_W-1:0]  format_in,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
`ifdef PARAM_LOADER_CHECKSUM_EN
    input  logic [DATA_W-1:0] expected_sum,
    output logic [DATA_W-1:0] checksum,
    output logic              checksum_err,
`endif
    output logic              in_ready,
    output logic              mem_write_en,
    output logic              mem_chip_en,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [FMT_W-1:0]  mem_write_format,
    output logic              busy,
    output logic              done,
    output logic              start_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_LAST = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   total_q;
    logic [FMT_W-1:0]  fmt_q;
    logic [ADDR_W:0]   count_next;
    logic              handshake;

    assign in_ready    = (state == S_LOAD);
    assign busy        = (state != S_IDLE);
    assign mem_chip_en = busy;
    assign handshake   = in_valid && in_ready;
    assign count_next  = count_q + {{ADDR_W{1'b0}}, 1'b1};

`ifdef PARAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] exp_q;
    logic [DATA_W-1:0] sum_next;
    assign sum_next = checksum + in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            addr_q           <= '0;
            count_q          <= '0;
            total_q          <= '0;
            fmt_q            <= '0;
            mem_write_en     <= 1'b0;
            mem_write_addr   <= '0;
            mem_write_data   <= '0;
            mem_write_format <= '0;
            done             <= 1'b0;
            start_err        <= 1'b0;
`ifdef PARAM_LOADER_CHECKSUM_EN
            exp_q            <= '0;
            checksum         <= '0;
            checksum_err     <= 1'b0;
`endif
        end else begin
            mem_write_en <= 1'b0;
            done         <= 1'b0;
            start_err    <= 1'b0;
`ifdef PARAM_LOADER_CHECKSUM_EN
            checksum_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
`ifdef PARAM_LOADER_CHECKSUM_EN
                        exp_q    <= expected_sum;
                        checksum <= '0;
`endif
                        if (word_count != '0) begin
                            addr_q  <= base_addr;
                            total_q <= word_count;
                            fmt_q   <= format_in;
                            count_q <= '0;
                            state   <= S_LOAD;
                        end else begin
                            // Empty load completes immediately; the empty
                            // sum is still checked against the expectation.
                            done <= 1'b1;
`ifdef PARAM_LOADER_CHECKSUM_EN
                            checksum_err <= (expected_sum != '0);
`endif
                        end
                    end
                end
                S_LOAD: begin
                    if (start) begin
                        start_err <= 1'b1;
                    end
                    if (handshake) begin
                        mem_write_en     <= 1'b1;
                        mem_write_addr   <= addr_q;
                        mem_write_data   <= in_data;
                        mem_write_format <= fmt_q;
                        addr_q           <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        count_q          <= count_next;
`ifdef PARAM_LOADER_CHECKSUM_EN
                        checksum         <= sum_next;
`endif
                        // done is registered here so it lands in LAST,
                        // together with the final write.
                        if (count_next == total_q) begin
                            state <= S_LAST;
                            done  <= 1'b1;
`ifdef PARAM_LOADER_CHECKSUM_EN
                            checksum_err <= (sum_next != exp_q);
`endif
                        end
                    end
                end
                S_LAST: begin
                    if (start) begin
                        start_err <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_loader.sv
// Self-checking bench for param_loader. A load is described by its base,
// count, format and word list; expected writes are (base+i) mod 2^15 with
// word i, one cycle after each accepted word.
module tb_param_loader;

    localparam int DATA_W = 22;
    localparam int ADDR_W = 15;
    localparam int FMT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [FMT_W-1:0]  format_in;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] expected_sum;
`ifdef PARAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
    logic              checksum_err;
`endif
    logic              in_ready;
    logic              mem_write_en;
    logic              mem_chip_en;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [FMT_W-1:0]  mem_write_format;
    logic              busy;
    logic              done;
    logic              start_err;

    int vectors    = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] wq[$];

    param_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FMT_W(FMT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .base_addr        (base_addr),
        .word_count       (word_count),
        .format_in        (format_in),
        .in_valid         (in_valid),
        .in_data          (in_data),
`ifdef PARAM_LOADER_CHECKSUM_EN
        .expected_sum     (expected_sum),
        .checksum         (checksum),
        .checksum_err     (checksum_err),
`endif
        .in_ready         (in_ready),
        .mem_write_en     (mem_write_en),
        .mem_chip_en      (mem_chip_en),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .mem_write_format (mem_write_format),
        .busy             (busy),
        .done             (done),
        .start_err        (start_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_wen"}, 64'(mem_write_en), 64'(0));
        check({tag, "_chip_en"}, 64'(mem_chip_en), 64'(0));
        check({tag, "_addr"}, 64'(mem_write_addr), 64'(0));
        check({tag, "_data"}, 64'(mem_write_data), 64'(0));
        check({tag, "_fmt"}, 64'(mem_write_format), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_start_err"}, 64'(start_err), 64'(0));
`ifdef PARAM_LOADER_CHECKSUM_EN
        check({tag, "_checksum"}, 64'(checksum), 64'(0));
        check({tag, "_cksum_err"}, 64'(checksum_err), 64'(0));
`endif
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(DATA_W'($urandom));
    endtask

    // vmode: 0 = valid always high, 1 = random valid, 2 = valid from pat (LSB first, then high)
    // err_cyc: stream cycle in which a second start is driven (-1: none)
    // abort_after: number of accepted words after which reset is applied (-1: none)
    task automatic do_load(input logic [ADDR_W-1:0] base, input int cnt, input logic [FMT_W-1:0] fmt,
                           input logic [DATA_W-1:0] exp_sum, input int vmode, input logic [31:0] pat,
                           input int err_cyc, input int abort_after);
        logic [DATA_W-1:0] sum;
        logic v;
        logic s;
        int idx;
        int cyc;
        sum = '0;
        for (int i = 0; i < cnt; i++) sum = sum + wq[i];

        in_valid     = 1'b0;
        base_addr    = base;
        word_count   = (ADDR_W+1)'(cnt);
        format_in    = fmt;
        expected_sum = exp_sum;
        start        = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = ADDR_W'($urandom);
        word_count = (ADDR_W+1)'($urandom);
        format_in  = FMT_W'($urandom);
        expected_sum = DATA_W'($urandom);

        if (cnt == 0) begin
            check("zero_done", 64'(done), 64'(1));
            check("zero_busy", 64'(busy), 64'(0));
            check("zero_wen", 64'(mem_write_en), 64'(0));
            check("zero_chip_en", 64'(mem_chip_en), 64'(0));
`ifdef PARAM_LOADER_CHECKSUM_EN
            check("zero_checksum", 64'(checksum), 64'(0));
            check("zero_cksum_err", 64'(checksum_err), 64'(exp_sum != '0));
`endif
            @(posedge clk); #1;
            check("zero_done_clr", 64'(done), 64'(0));
            check("zero_wen_after", 64'(mem_write_en), 64'(0));
            return;
        end

        check("start_busy", 64'(busy), 64'(1));
        check("start_in_ready", 64'(in_ready), 64'(1));
        check("start_chip_en", 64'(mem_chip_en), 64'(1));
        check("start_wen", 64'(mem_write_en), 64'(0));
        check("start_done", 64'(done), 64'(0));

        idx = 0;
        cyc = 0;
        while (idx < cnt) begin
            if (abort_after >= 0 && idx == abort_after) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check_all_zero("reset_mid");
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                check_all_zero("reset_after");
                return;
            end
            if (cyc >= 300) begin
                check("stream_timeout", 64'(1), 64'(0));
                return;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = (cyc < 32) ? pat[cyc] : 1'b1;
            endcase
            in_valid = v;
            in_data  = v ? wq[idx] : DATA_W'($urandom);
            start    = (cyc == err_cyc);
            if (start) base_addr = 15'h50;
            @(posedge clk); #1;
            start = 1'b0;
            check("wen", 64'(mem_write_en), 64'(v));
            if (v) begin
                check("wr_addr", 64'(mem_write_addr), 64'(ADDR_W'(base + ADDR_W'(idx))));
                check("wr_data", 64'(mem_write_data), 64'(wq[idx]));
                check("wr_fmt", 64'(mem_write_format), 64'(fmt));
            end
            check("chip_en", 64'(mem_chip_en), 64'(1));
            check("start_err", 64'(start_err), 64'(cyc == err_cyc));
            check("done", 64'(done), 64'(v && idx == cnt - 1));
            if (v) idx++;
            cyc++;
            check("in_ready", 64'(in_ready), 64'(idx < cnt));
            check("busy", 64'(busy), 64'(1));
        end

`ifdef PARAM_LOADER_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(sum));
        check("cksum_err", 64'(checksum_err), 64'(sum != exp_sum));
`endif
        // Final cycle: stream keeps offering words and start may arrive in LAST.
        s = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        in_data  = DATA_W'($urandom);
        start    = s;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("end_busy", 64'(busy), 64'(0));
        check("end_in_ready", 64'(in_ready), 64'(0));
        check("end_chip_en", 64'(mem_chip_en), 64'(0));
        check("end_done", 64'(done), 64'(0));
        check("end_wen", 64'(mem_write_en), 64'(0));
        check("last_start_err", 64'(start_err), 64'(s));
`ifdef PARAM_LOADER_CHECKSUM_EN
        check("end_cksum_err", 64'(checksum_err), 64'(0));
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        format_in = '0;
        in_valid = 1'b0;
        in_data = '0;
        expected_sum = '0;
        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle");

        // Reset after 2 of 4 words, then a single-word load at 0x20.
        fill_random(4);
        do_load(15'h0010, 4, 2'd1, '0, 0, '0, -1, 2);
        fill_random(1);
        do_load(15'h0020, 1, 2'd2, '0, 0, '0, -1, -1);

        // Back-to-back words 1..4 at 0x0100.
        wq = '{22'd1, 22'd2, 22'd3, 22'd4};
        do_load(15'h0100, 4, 2'd3, '0, 0, '0, -1, -1);

        // Throttled stream: valid 1,0,0,1,0,1.
        fill_random(3);
        do_load(15'h0200, 3, 2'd1, '0, 2, 32'b101001, -1, -1);

        // Address wrap, then an empty load.
        fill_random(3);
        do_load(15'h7FFE, 3, 2'd2, '0, 0, '0, -1, -1);
        fill_random(2);
        do_load(15'h7FFF, 2, 2'd0, '0, 1, '0, -1, -1);
        wq.delete();
        do_load(15'h1234, 0, 2'd1, '0, 0, '0, -1, -1);
        do_load(15'h1234, 0, 2'd1, 22'd5, 0, '0, -1, -1);

        // Second start two cycles into a 4-word load.
        fill_random(4);
        do_load(15'h0300, 4, 2'd3, '0, 0, '0, 2, -1);
        fill_random(4);
        do_load(15'h0400, 4, 2'd1, '0, 1, '0, 1, -1);

        // Checksum match and mismatch.
        wq = '{22'd10, 22'd20, 22'd30};
        do_load(15'h0500, 3, 2'd0, 22'd60, 0, '0, -1, -1);
        wq = '{22'd10, 22'd20, 22'd30};
        do_load(15'h0500, 3, 2'd0, 22'd61, 0, '0, -1, -1);

        // Randomised loads.
        for (int n = 0; n < 20; n++) begin
            int c;
            logic [DATA_W-1:0] es;
            c = $urandom_range(1, 16);
            fill_random(c);
            es = DATA_W'($urandom);
            if (n % 2 == 0) begin
                es = '0;
                for (int i = 0; i < c; i++) es = es + wq[i];
            end
            do_load(ADDR_W'($urandom), c, FMT_W'($urandom), es, 1, '0,
                    (n % 3 == 0) ? int'($urandom_range(0, 4)) : -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
